// File: rtl/mips_fetch_pkg.sv
// Shared constants and FSM type for the MIPS instruction fetch stage.
package mips_fetch_pkg;

  localparam int          ADDR_W   = 10;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // FILL: no live memory request outstanding; RUN: last sampled address is live.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_ifid_register.sv
// IF/ID pipeline register: holds on stall, loads a bubble on flush.
module ifid_register
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_VALUE = mips_fetch_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  input  logic        d_valid,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc,
  output logic [31:0] q_pc4,
  output logic        q_valid
);

  // Flush beats hold; pc/pc4 keep their last value on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_instr <= NOP_VALUE;
      q_pc    <= 32'h0;
      q_pc4   <= 32'h4;
      q_valid <= 1'b0;
    end else if (flush) begin
      q_instr <= NOP_VALUE;
      q_valid <= 1'b0;
    end else if (!hold) begin
      q_instr <= d_instr;
      q_pc    <= d_pc;
      q_pc4   <= d_pc + 32'h4;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, drives the memory word address and feeds IF/ID.
module instruction_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_fetch_pkg::RESET_PC,
  parameter int          ADDR_W   = mips_fetch_pkg::ADDR_W,
  parameter logic [31:0] NOP_WORD = mips_fetch_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Instruction,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc4,
  output logic              if_valid,
  output logic [31:0]       fetch_count
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         req_valid;
  logic         advance;
  logic [31:0]  held_instr;
  logic         held;
  logic [31:0]  fetch_data;
  logic [31:0]  count;
  logic         unused_low_bits;

  assign advance         = !redirect && !stall;
  assign Addr            = pc[ADDR_W+1:2];
  assign fetch_count     = count;
  assign unused_low_bits = ^redirect_pc[1:0];

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  // FSM next state: redirect drops the live request, stall freezes, otherwise run.
  always_comb begin
    state_next = state;
    if (redirect)     state_next = FILL;
    else if (!stall)  state_next = RUN;
  end

  // FSM outputs: the request sampled on the last edge is live only in RUN.
  always_comb begin
    req_valid = 1'b0;
    if (state == RUN) req_valid = 1'b1;
  end

  // PC and outstanding-request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      req_pc <= 32'h0;
    end else if (redirect) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      req_pc <= pc;
      pc     <= pc + 32'h4;
    end
  end

  // A synchronous memory keeps reading Addr (which is the next PC, not req_pc)
  // during a stall, so the word belonging to req_pc is captured on the first
  // stalled edge and replayed when the stall releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held       <= 1'b0;
      held_instr <= NOP_WORD;
    end else if (!stall || redirect) begin
      held <= 1'b0;
    end else if (!held) begin
      held       <= 1'b1;
      held_instr <= Instruction;
    end
  end

  assign fetch_data = held ? held_instr : Instruction;

  // Count instructions handed to decode as valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= 32'h0;
    else if (advance && req_valid)  count <= count + 32'h1;
  end

  ifid_register #(
    .NOP_VALUE(NOP_WORD)
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .hold    (stall),
    .flush   (redirect),
    .d_instr (fetch_data),
    .d_pc    (req_pc),
    .d_valid (req_valid),
    .q_instr (if_instr),
    .q_pc    (if_pc),
    .q_pc4   (if_pc4),
    .q_valid (if_valid)
  );

endmodule
